uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_rr_arb.sv | 31 +++
 rtl/uart_tx_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the multi-requester UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  // Channel header: base value with the owner index in the low three bits.
  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] idx);
    return base | {5'd0, idx};
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first requester after the pointer wins.
module uart_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [GW-1:0]      o_gnt_idx,
  output logic               o_any
);

  logic [GW-1:0] w_idx;

  // Walk ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; the pointer itself is checked last.
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_gnt_oh[w_idx] = 1'b1;
        o_gnt_idx       = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding several byte streams into one UART
// transmitter, optionally prefixing each packet with a channel header byte.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned HDR_EN   = 1,
  parameter logic [7:0]  HDR_BASE = HDR_BASE_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0][7:0]       req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [7:0]                    tx_data_o,
  input  logic                          tx_ready_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_o
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [GW-1:0]      r_grant;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [GW-1:0]      r_last;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [GW-1:0]      w_gnt_idx;
  logic               w_any;
  logic               w_owner_valid;
  logic               w_pkt_done;
  logic [7:0]         w_hdr;

  uart_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr (
    .i_req     (req_valid_i),
    .i_ptr     (r_last),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_hdr         = hdr_byte(HDR_BASE, 3'(r_grant));
  assign w_owner_valid = |(req_valid_i & r_grant_oh);

  // Next state and output mux; data phase is a zero-latency pass-through.
  always_comb begin
    w_next      = r_state;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    w_pkt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = (HDR_EN != 0) ? ST_HDR : ST_DATA;
      end
      ST_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = w_hdr;
        if (tx_ready_i) w_next = ST_DATA;
      end
      ST_DATA: begin
        tx_valid_o  = w_owner_valid;
        tx_data_o   = req_data_i[r_grant];
        req_ready_o = r_grant_oh & {NUM_REQ{tx_ready_i}};
        w_pkt_done  = w_owner_valid && tx_ready_i && req_last_i[r_grant];
        if (w_pkt_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Nothing is offered or accepted while reset is asserted.
    if (rst_i) begin
      tx_valid_o  = 1'b0;
      req_ready_o = '0;
      w_pkt_done  = 1'b0;
      w_next      = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_last     <= GW'(NUM_REQ - 1);
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      if (r_state == ST_IDLE && w_any) begin
        r_grant    <= w_gnt_idx;
        r_grant_oh <= w_gnt_oh;
      end
      if (w_pkt_done) r_last <= r_grant;
    end
  end

  assign busy_o  = r_busy;
  assign grant_o = r_grant;

endmodule
